// File: rtl/avr_uart_pkg.sv
// avr_uart_pkg: shared state type and frame constants for the AVR UART receiver.
// Optional feature macro: AVR_UART_RX_PARITY_EN adds the PARITY state (8E1 frames).
package avr_uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef AVR_UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } uart_rx_state_t;

endpackage

// File: rtl/avr_uart_rx_fifo.sv
// avr_uart_rx_fifo: small synchronous FIFO holding decoded bytes.
// The head byte is held in a register so the consumer sees a stable value;
// a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module avr_uart_rx_fifo
   import avr_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = UART_DATA_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic              pop_eff;
   logic              push_ok;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = head_q;

   // Next pointers, occupancy, storage and head byte after this cycle's push/pop.
   always_comb begin
      pop_eff  = pop && !empty;
      push_ok  = push && (!full || pop_eff);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_eff);
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wr_data;
      end
      head_d = mem_d[rd_ptr_d];
   end

   // FIFO storage and pointer registers, cleared to empty on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/avr_uart_rx.sv
// avr_uart_rx: decodes UART frames from a simulated AVR TXD pin into bytes.
// A 2-flop synchronizer feeds a mid-bit-sampling frame FSM; good bytes go
// into avr_uart_rx_fifo and leave through a valid/ready port.
// Optional feature macro: AVR_UART_RX_PARITY_EN selects 8E1 instead of 8N1.
module avr_uart_rx
   import avr_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 416,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rxd,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic                      busy,
   output logic                      frame_err,
   output logic                      overrun,
   output logic                      parity_err
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int BIT_W    = $clog2(UART_DATA_BITS);

   logic [1:0]                sync_q, sync_d;
   logic                      rxs;
   uart_rx_state_t            state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [BIT_W-1:0]          bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      frame_err_q, frame_err_d;
   logic                      overrun_q, overrun_d;
   logic                      push;
   logic                      pop;
   logic                      fifo_full;
   logic                      fifo_empty;
`ifdef AVR_UART_RX_PARITY_EN
   logic                      par_bad_q, par_bad_d;
   logic                      parity_err_q, parity_err_d;
`endif

   assign rxs       = sync_q[1];
   assign rx_valid  = !fifo_empty;
   assign pop       = rx_valid && rx_ready;
   assign busy      = (state_q != IDLE);
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
`ifdef AVR_UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   // Shift the asynchronous pin level through two flops before any use.
   always_comb begin
      sync_d = {sync_q[0], rxd};
   end

   // Frame FSM: start detect, half-bit start check, then one sample per bit period.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      bit_d       = bit_q;
      shift_d     = shift_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
`ifdef AVR_UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxs) begin
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
               cnt_d   = '0;
               state_d = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
               bit_d   = bit_q + BIT_W'(1);
               if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
`ifdef AVR_UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef AVR_UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d     = '0;
               par_bad_d = ^{shift_q, rxs};
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (!rxs) begin
                  frame_err_d = 1'b1;
`ifdef AVR_UART_RX_PARITY_EN
               end else if (par_bad_q) begin
                  parity_err_d = 1'b1;
`endif
               end else begin
                  push = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      overrun_d = push && fifo_full && !pop;
   end

   // State, counters, shift register and registered one-cycle error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= 2'b11;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef AVR_UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef AVR_UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   avr_uart_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_W     (UART_DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (shift_q),
      .pop     (pop),
      .rd_data (rx_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_avr_uart_rx.sv
// tb_avr_uart_rx: table-driven frames plus hand-written corner sequences for avr_uart_rx.
// Received bytes are checked against a scoreboard queue filled as frames are sent.
`timescale 1ns/1ps
module tb_avr_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
`ifdef AVR_UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int LAT = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;

   logic       clk;
   logic       rst;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       busy;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int valid_cnt, fe_cnt, ov_cnt, pe_cnt, busy_cnt, evt_cyc, fe_cyc;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      bit         stop_bit;
      int         exp_valid;
      int         exp_fe;
   } vec_t;

   vec_t vecs[6];

   avr_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .busy       (busy),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   // Free-running clock and cycle counter used to time output events.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // Output monitor on the falling edge: counts pulses and scores popped bytes.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            valid_cnt++;
            if (evt_cyc < 0) evt_cyc = cyc;
         end
         if (frame_err) begin
            fe_cnt++;
            if (fe_cyc < 0) fe_cyc = cyc;
         end
         if (overrun) ov_cnt++;
         if (parity_err) pe_cnt++;
         if (busy) busy_cnt++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("[TB] FAIL rx_byte: actual=%0h required=none (scoreboard empty)", rx_data);
            end else begin
               checkOutput("rx_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clearCounters();
      valid_cnt = 0;
      fe_cnt    = 0;
      ov_cnt    = 0;
      pe_cnt    = 0;
      busy_cnt  = 0;
      evt_cyc   = -1;
      fe_cyc    = -1;
   endtask

   task automatic sendBit(input logic v);
      rxd = v;
      tick(CPB);
   endtask

   // Drives one full frame; par_flip inverts the even-parity bit when parity is built in.
   task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input bit par_flip,
                                output int c0);
      logic par_bit;
      par_bit = (^data) ^ par_flip;
      c0 = cyc;
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(data[i]);
`ifdef AVR_UART_RX_PARITY_EN
      sendBit(par_bit);
`endif
      sendBit(stop_bit);
      rxd = 1'b1;
   endtask

   initial begin
      int c0;
      vecs[0] = '{8'h55, 1'b1, 1, 0};
      vecs[1] = '{8'hA3, 1'b0, 0, 1};
      vecs[2] = '{8'h00, 1'b1, 1, 0};
      vecs[3] = '{8'hFF, 1'b1, 1, 0};
      vecs[4] = '{8'h80, 1'b1, 1, 0};
      vecs[5] = '{8'h01, 1'b1, 1, 0};

      rst = 1'b1;
      rxd = 1'b1;
      rx_ready = 1'b1;
      clearCounters();
      tick(2);
      checkOutput("reset_rx_valid", rx_valid, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_frame_err", frame_err, 0);
      checkOutput("reset_overrun", overrun, 0);
      checkOutput("reset_parity_err", parity_err, 0);
      checkOutput("reset_rx_data", rx_data, 8'h00);
      rst = 1'b0;
      tick(4);

      for (int i = 0; i < 6; i++) begin
         clearCounters();
         if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].data);
         applyStimulus(vecs[i].data, vecs[i].stop_bit, 1'b0, c0);
         tick(4);
         checkOutput($sformatf("v%0d_valid_cycles", i), valid_cnt, vecs[i].exp_valid);
         checkOutput($sformatf("v%0d_frame_err", i), fe_cnt, vecs[i].exp_fe);
         checkOutput($sformatf("v%0d_overrun", i), ov_cnt, 0);
         checkOutput($sformatf("v%0d_parity_err", i), pe_cnt, 0);
         checkOutput($sformatf("v%0d_scoreboard_empty", i), exp_q.size(), 0);
         checkOutput($sformatf("v%0d_busy_idle", i), busy, 0);
         if (vecs[i].exp_valid != 0)
            checkOutput($sformatf("v%0d_valid_latency", i), evt_cyc - c0, LAT);
         if (vecs[i].exp_fe != 0)
            checkOutput($sformatf("v%0d_ferr_latency", i), fe_cyc - c0, LAT);
      end

      // Start glitch shorter than half a bit: busy for the start check only.
      clearCounters();
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(2 * CPB);
      checkOutput("glitch_busy_cycles", busy_cnt, CPB / 2);
      checkOutput("glitch_valid", valid_cnt, 0);
      checkOutput("glitch_flags", fe_cnt + ov_cnt + pe_cnt, 0);

      // Five back-to-back bytes into a stalled FIFO, then a full-rate drain.
      rx_ready = 1'b0;
      clearCounters();
      for (int b = 1; b <= 5; b++) begin
         if (b <= DEPTH) exp_q.push_back(8'(b));
         applyStimulus(8'(b), 1'b1, 1'b0, c0);
      end
      tick(2);
      checkOutput("ovr_pulses", ov_cnt, 1);
      checkOutput("ovr_frame_err", fe_cnt, 0);
      checkOutput("ovr_head_valid", rx_valid, 1);
      checkOutput("ovr_head_data", rx_data, 8'h01);
      clearCounters();
      rx_ready = 1'b1;
      tick(DEPTH);
      checkOutput("drain_valid_cycles", valid_cnt, DEPTH);
      checkOutput("drain_empty", rx_valid, 0);
      checkOutput("drain_scoreboard", exp_q.size(), 0);

      // Reset in the middle of data bit 3, then a clean frame.
      clearCounters();
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) sendBit(1'b1);
      rxd = 1'b1;
      tick(CPB / 2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_valid", rx_valid, 0);
      tick(3 * CPB);
      checkOutput("midrst_flags", fe_cnt + ov_cnt + pe_cnt, 0);
      checkOutput("midrst_no_byte", valid_cnt, 0);
      clearCounters();
      exp_q.push_back(8'h7E);
      applyStimulus(8'h7E, 1'b1, 1'b0, c0);
      tick(4);
      checkOutput("after_rst_valid_cycles", valid_cnt, 1);
      checkOutput("after_rst_scoreboard", exp_q.size(), 0);

`ifdef AVR_UART_RX_PARITY_EN
      // Bad parity drops the byte; correct parity delivers it.
      clearCounters();
      applyStimulus(8'h07, 1'b1, 1'b1, c0);
      tick(4);
      checkOutput("par_bad_pulse", pe_cnt, 1);
      checkOutput("par_bad_valid", valid_cnt, 0);
      checkOutput("par_bad_ferr", fe_cnt, 0);
      clearCounters();
      exp_q.push_back(8'h07);
      applyStimulus(8'h07, 1'b1, 1'b0, c0);
      tick(4);
      checkOutput("par_ok_valid", valid_cnt, 1);
      checkOutput("par_ok_perr", pe_cnt, 0);
      checkOutput("par_ok_scoreboard", exp_q.size(), 0);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/avr_uart_rx.md
# avr_uart_rx

Serial receiver sitting directly downstream of a simulated AVR's TXD pin (the value `$avr_get_pin` returns, e.g. pin "D1"), decoding 8N1 frames into bytes for the Verilog side of co-simulation benches. Synchronizes the asynchronous pin level, runs a mid-bit-sampling frame state machine, and buffers decoded bytes in a small FIFO with a valid/ready output. Lets benches check AVR serial output on clock edges instead of polling pin values in behavioural code.

## Interface
- `CLKS_PER_BIT`, 416, `clk` cycles per UART bit (4 MHz / 9600 Bd); legal ≥ 4.
- `FIFO_DEPTH`, 4, byte entries; power of two, ≥ 2.
- `clk`  in  1  system clock, the same 4 MHz bench `clk` that drives `$avr_tick`.
- `rst`  in  1  synchronous, active-high reset; one clock, sampled on rising `clk`.
- `rxd`  in  1  AVR TXD pin level, asynchronous; idle high.
- `rx_data`  out  8  byte at the FIFO head; valid only while `rx_valid` is high.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts the head byte on a cycle where `rx_valid && rx_ready`.
- `busy`  out  1  frame state machine is not IDLE.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (constant 0 without the macro).

## Operation
- 2-flop synchronizer on `rxd`, reset to 1. All logic uses the synchronized value `rxs`.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - On the first cycle with `rxs == 0`, clear the bit counter and go to START.
- START:
  - Sample `rxs` after `CLKS_PER_BIT/2` cycles (integer division).
  - If it is 1, treat it as a glitch: return to IDLE with no flags.
  - If it is 0, go to DATA.
- DATA:
  - Sample 8 bits, LSB first, each `CLKS_PER_BIT` cycles after the previous sample.
  - Then go to PARITY if the macro is defined, otherwise to STOP.
- STOP:
  - Sample one bit `CLKS_PER_BIT` cycles after the previous sample.
  - Sample 0: pulse `frame_err` and discard the byte.
  - Sample 1: push the byte (see the error priority rule under Configuration).
  - Return to IDLE right after the stop sample, so the next start edge can be caught in the second half of the stop bit.
- FIFO push:
  - Full with no pop this cycle: drop the byte and pulse `overrun`.
  - Full with a pop this cycle: the push succeeds and there is no overrun.
- FIFO pop occurs on `rx_valid && rx_ready`. Pointers wrap modulo `FIFO_DEPTH`.
- `busy` is high in every state except IDLE.
- Reset values:
  - `rx_valid`, `busy`, `frame_err`, `overrun`, `parity_err` are 0.
  - `rx_data` is 8'h00.
  - FIFO is empty, state is IDLE.
- Reset mid-frame: the partial byte is lost and no flags fire. Reset does not clear an ongoing low level on `rxd`; the machine restarts from IDLE.

## Timing
- `rxd` → `rxs` latency: 2 cycles.
- Let E be the first cycle of IDLE with `rxs == 0`:
  - Start sample at E + `CLKS_PER_BIT/2`.
  - Data bit k sample at E + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - Stop sample at E + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` without the macro, + 10·`CLKS_PER_BIT` with it.
- Stop sample at cycle S:
  - FIFO write, `frame_err`, `overrun`, `parity_err` are all registered and visible at S+1.
  - `rx_valid` rises at S+1 if the FIFO was empty.
- `rx_data` is registered from the FIFO head and changes the cycle after a pop.
- Sustained throughput: one byte per frame. The FIFO can be drained at one byte per clock.

## Configuration
- `AVR_UART_RX_PARITY_EN`:
  - Defined: 8E1 frames. Sample an even-parity bit after the data bits; the stop bit follows.
  - Parity mismatch with a good stop bit: pulse `parity_err` and discard the byte.
  - Error priority: if the stop bit is also low, only `frame_err` pulses.
  - Undefined: 8N1 frames, no PARITY state, `parity_err` tied 0.

## Structure
- Package `avr_uart_pkg`: state enum `uart_rx_state_t` and the constant `UART_DATA_BITS = 8`.
- Sub-module `avr_uart_rx_fifo`, parameterized by `FIFO_DEPTH`. It provides a synchronous FIFO with push/pop, full/empty, and registered head data.
- The synchronizer and state machine live in `avr_uart_rx`.

## Test plan
- `CLKS_PER_BIT=16`, `rx_ready=1`, drive frame 0x55 → `rx_valid` high exactly one cycle with `rx_data=0x55`; `frame_err`, `overrun`, `parity_err` all 0.
- `rxd` low for 3 cycles then high (`CLKS_PER_BIT=16`) → `busy` high then back to 0 at the start sample; no `rx_valid`, no flags.
- Frame 0xA3 with the stop bit driven 0 → `frame_err` one-cycle pulse at S+1; FIFO stays empty.
- `rx_ready=0`, send 0x01..0x05 back to back, `FIFO_DEPTH=4` → a single `overrun` pulse on the fifth byte; raising `rx_ready` drains 01, 02, 03, 04 on consecutive cycles.
- Assert `rst` for one cycle during data bit 3 → `busy=0` and `rx_valid=0` the next cycle; a following frame 0x7E is received correctly.
- With `AVR_UART_RX_PARITY_EN`: 0x07 with parity bit 0 → `parity_err` pulse, no push. Same byte with parity bit 1 → 0x07 delivered.
